// File: rtl/paddle_ctrl.sv
// paddle_ctrl: paddle X-position controller for the brick-breaker game.
// Held left/right key levels move the paddle once per game tick, with stepped
// acceleration up to MAX_SPEED and clamping at MIN_X / MAX_X.
// Optional build macro PADDLE_INERTIA_EN adds a BRAKE state (coast-down).
module paddle_ctrl #(
   parameter int unsigned MIN_X       = 0,
   parameter int unsigned MAX_X       = 560,
   parameter int unsigned CENTER_X    = 280,
   parameter int unsigned MAX_SPEED   = 8,
   parameter int unsigned ACCEL_TICKS = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       key_left,
   input  logic       key_right,
   input  logic       freeze,
   output logic [9:0] board_x,
   output logic [3:0] speed,
   output logic [1:0] dir,
   output logic       at_wall
);

   localparam int unsigned ACC_W = $clog2(ACCEL_TICKS);

   localparam logic [9:0]       MIN10    = 10'(MIN_X);
   localparam logic [9:0]       MAX10    = 10'(MAX_X);
   localparam logic [9:0]       CENTER10 = 10'(CENTER_X);
   localparam logic [10:0]      MIN11    = 11'(MIN_X);
   localparam logic [10:0]      MAX11    = 11'(MAX_X);
   localparam logic [3:0]       MAX_S    = 4'(MAX_SPEED);
   localparam logic [ACC_W-1:0] ACC_ONE  = ACC_W'(1);
   localparam logic [ACC_W-1:0] ACC_LAST = ACC_W'(ACCEL_TICKS - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_LEFT  = 2'b01,
      S_RIGHT = 2'b10,
      S_BRAKE = 2'b11
   } state_t;

   state_t           state, state_n;
   logic [ACC_W-1:0] acc, acc_n;
   logic [9:0]       x_n;
   logic [3:0]       spd_n;
   logic [3:0]       step_s;
   logic [3:0]       accel_s;
   logic [ACC_W-1:0] accel_acc;
   logic             l_only, r_only;
   logic             mv, mv_left, fresh, clamped;
   logic [10:0]      bx11, s11, sum11;
`ifdef PADDLE_INERTIA_EN
   logic             brk_left, brk_left_n;
`endif

   assign l_only  = key_left & ~key_right;
   assign r_only  = key_right & ~key_left;
   assign dir     = state;
   assign at_wall = (board_x == MIN10) || (board_x == MAX10);

   // Next-state, next-speed and next-position decision for one game tick.
   // The entry tick into a MOVE state counts as the first held tick, so acc
   // starts at 1 there. A speed-1 entry move that hits the wall is clamped
   // but keeps MOVE; only an ongoing move that clamps drops back to IDLE,
   // which makes a held key at the wall alternate IDLE / MOVE.
   always_comb begin
      state_n = state;
      acc_n   = acc;
      step_s  = speed;
      mv      = 1'b0;
      mv_left = 1'b0;
      fresh   = 1'b0;
      clamped = 1'b0;
`ifdef PADDLE_INERTIA_EN
      brk_left_n = brk_left;
`endif
      if (acc == ACC_LAST) begin
         accel_acc = '0;
         accel_s   = (speed >= MAX_S) ? MAX_S : speed + 4'd1;
      end else begin
         accel_acc = acc + ACC_ONE;
         accel_s   = speed;
      end

      case (state)
         S_IDLE: begin
            if (l_only || r_only) begin
               state_n = l_only ? S_LEFT : S_RIGHT;
               step_s  = 4'd1;
               acc_n   = ACC_ONE;
               mv      = 1'b1;
               mv_left = l_only;
               fresh   = 1'b1;
            end
         end
         S_LEFT, S_RIGHT: begin
            if ((state == S_LEFT) ? l_only : r_only) begin
               step_s  = accel_s;
               acc_n   = accel_acc;
               mv      = 1'b1;
               mv_left = (state == S_LEFT);
            end
`ifdef PADDLE_INERTIA_EN
            else if (speed > 4'd1) begin
               state_n    = S_BRAKE;
               brk_left_n = (state == S_LEFT);
               step_s     = speed - 4'd1;
               mv         = 1'b1;
               mv_left    = (state == S_LEFT);
            end else begin
               state_n = S_IDLE;
               step_s  = '0;
               acc_n   = '0;
            end
`else
            else if ((state == S_LEFT) ? r_only : l_only) begin
               state_n = (state == S_LEFT) ? S_RIGHT : S_LEFT;
               step_s  = 4'd1;
               acc_n   = ACC_ONE;
               mv      = 1'b1;
               mv_left = (state == S_RIGHT);
               fresh   = 1'b1;
            end else begin
               state_n = S_IDLE;
               step_s  = '0;
               acc_n   = '0;
            end
`endif
         end
`ifdef PADDLE_INERTIA_EN
         S_BRAKE: begin
            if (brk_left ? l_only : r_only) begin
               state_n = brk_left ? S_LEFT : S_RIGHT;
               acc_n   = '0;
               mv      = 1'b1;
               mv_left = brk_left;
            end else if (speed > 4'd1) begin
               step_s  = speed - 4'd1;
               mv      = 1'b1;
               mv_left = brk_left;
            end else begin
               state_n = S_IDLE;
               step_s  = '0;
               acc_n   = '0;
            end
         end
`endif
         default: begin
            state_n = S_IDLE;
            step_s  = '0;
            acc_n   = '0;
         end
      endcase

      bx11  = {1'b0, board_x};
      s11   = {7'b0, step_s};
      sum11 = bx11 + s11;
      x_n   = board_x;
      if (mv) begin
         if (mv_left) begin
            if (bx11 < MIN11 + s11) begin
               x_n     = MIN10;
               clamped = 1'b1;
            end else begin
               x_n = board_x - {6'b0, step_s};
            end
         end else begin
            if (sum11 > MAX11) begin
               x_n     = MAX10;
               clamped = 1'b1;
            end else begin
               x_n = sum11[9:0];
            end
         end
      end

      spd_n = step_s;
      if (clamped && !fresh) begin
         state_n = S_IDLE;
         spd_n   = '0;
         acc_n   = '0;
      end
   end

   // State registers advance only on an unfrozen tick.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= S_IDLE;
         board_x <= CENTER10;
         speed   <= '0;
         acc     <= '0;
`ifdef PADDLE_INERTIA_EN
         brk_left <= 1'b0;
`endif
      end else if (tick && !freeze) begin
         state   <= state_n;
         board_x <= x_n;
         speed   <= spd_n;
         acc     <= acc_n;
`ifdef PADDLE_INERTIA_EN
         brk_left <= brk_left_n;
`endif
      end
   end

endmodule

// File: tb/tb_paddle_ctrl.sv
// tb_paddle_ctrl: scoreboard bench for paddle_ctrl (default parameters).
// Expected outputs come from a behavioural model stepped per tick and from
// fixed reference sequences.
module tb_paddle_ctrl;

   logic       clk = 1'b0;
   logic       rst, tick, key_left, key_right, freeze;
   logic [9:0] board_x;
   logic [3:0] speed;
   logic [1:0] dir;
   logic       at_wall;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [9:0] x;
      logic [3:0] s;
      logic [1:0] d;
      logic       w;
   } exp_t;

   exp_t sb[$];
   exp_t e;

   int mx, ms, md, macc;
   bit mbrk;

   paddle_ctrl #(
      .MIN_X(0), .MAX_X(560), .CENTER_X(280), .MAX_SPEED(8), .ACCEL_TICKS(4)
   ) dut (
      .clk(clk), .rst(rst), .tick(tick), .key_left(key_left),
      .key_right(key_right), .freeze(freeze), .board_x(board_x),
      .speed(speed), .dir(dir), .at_wall(at_wall)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog");
   end

   task automatic model_reset();
      mx = 280; ms = 0; md = 0; macc = 0; mbrk = 0;
   endtask

   task automatic push_model();
      exp_t t;
      t.x = mx[9:0];
      t.s = ms[3:0];
      t.d = md[1:0];
      t.w = (mx == 0) || (mx == 560);
      sb.push_back(t);
   endtask

   task automatic model_tick(input bit l, input bit r);
      bit lo, ro, same, opp, fresh, clamp;
      int ns, mvd;
      lo = l && !r; ro = r && !l;
      ns = ms; mvd = 0; fresh = 0; clamp = 0;
      same = (md == 1) ? lo : ro;
      opp  = (md == 1) ? ro : lo;
      case (md)
         0: if (lo || ro) begin
               md = lo ? 1 : 2; ns = 1; macc = 1; mvd = md; fresh = 1;
            end
         1, 2: begin
            if (same) begin
               mvd = md;
               if (macc == 3) begin macc = 0; ns = (ms + 1 > 8) ? 8 : ms + 1; end
               else macc++;
            end
`ifdef PADDLE_INERTIA_EN
            else if (ms > 1) begin mbrk = (md == 1); mvd = md; md = 3; ns = ms - 1; end
`else
            else if (opp) begin md = 3 - md; ns = 1; macc = 1; mvd = md; fresh = 1; end
`endif
            else begin md = 0; ns = 0; macc = 0; end
         end
         default: begin
            if ((mbrk && lo) || (!mbrk && ro)) begin md = mbrk ? 1 : 2; macc = 0; mvd = md; end
            else if (ms > 1) begin ns = ms - 1; mvd = mbrk ? 1 : 2; end
            else begin md = 0; ns = 0; macc = 0; end
         end
      endcase
      if (mvd == 1) begin
         if (mx < ns) begin mx = 0; clamp = 1; end else mx = mx - ns;
      end else if (mvd == 2) begin
         if (mx + ns > 560) begin mx = 560; clamp = 1; end else mx = mx + ns;
      end
      ms = ns;
      if (clamp && !fresh) begin md = 0; ms = 0; macc = 0; end
   endtask

   // One tick cycle: drive keys, record the expectation, sample #1 after the edge.
   task automatic do_tick(input bit l, input bit r, input bit f);
      @(negedge clk);
      key_left = l; key_right = r; freeze = f; tick = 1'b1;
      if (!f) model_tick(l, r);
      push_model();
      @(posedge clk);
      #1;
      tick = 1'b0;
   endtask

   task automatic async_reset();
      @(negedge clk);
      #2 rst = 1'b0;
      model_reset();
      #1;
      total++;
      if (board_x !== 10'd280 || speed !== 4'd0 || dir !== 2'd0 || at_wall !== 1'b0) begin
         bad++;
         $display("FAIL async_reset: got x=%0d s=%0d d=%0d w=%0d required x=280 s=0 d=0 w=0",
                  board_x, speed, dir, at_wall);
      end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0; tick = 1'b0; key_left = 1'b0; key_right = 1'b1; freeze = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      for (int i = 0; i < 6; i++) begin
         if (i > 0) begin
            @(negedge clk); tick = 1'b1;
            @(posedge clk); #1; tick = 1'b0;
         end else #1;
         total++;
         if (board_x !== 10'd280 || speed !== 4'd0 || dir !== 2'd0 || at_wall !== 1'b0) begin
            bad++;
            $display("FAIL reset[%0d]: got x=%0d s=%0d d=%0d w=%0d required x=280 s=0 d=0 w=0",
                     i, board_x, speed, dir, at_wall);
         end
      end
      @(negedge clk);
      rst = 1'b1; key_right = 1'b0;
   endtask

   task automatic test_accel();
      int xs[6] = '{279, 278, 277, 275, 273, 271};
      int sp[6] = '{1, 1, 1, 2, 2, 2};
      for (int i = 0; i < 8; i++) begin
         do_tick(i < 6, 1'b0, 1'b0);
         e = sb.pop_front();
         total++;
         if (board_x !== e.x || speed !== e.s || dir !== e.d || at_wall !== e.w) begin
            bad++;
            $display("FAIL accel_sb[%0d]: got x=%0d s=%0d d=%0d w=%0d required x=%0d s=%0d d=%0d w=%0d",
                     i, board_x, speed, dir, at_wall, e.x, e.s, e.d, e.w);
         end
         if (i < 6) begin
            total++;
            if (board_x !== 10'(xs[i]) || speed !== 4'(sp[i]) || dir !== 2'd1) begin
               bad++;
               $display("FAIL accel_seq[%0d]: got x=%0d s=%0d d=%0d required x=%0d s=%0d d=1",
                        i, board_x, speed, dir, xs[i], sp[i]);
            end
         end
      end
   endtask

   task automatic test_right_wall();
      int n = 0;
      logic [1:0] pd;
      async_reset();
      while (board_x != 10'd560 && n < 150) begin
         do_tick(1'b0, 1'b1, 1'b0);
         n++;
         e = sb.pop_front();
         total++;
         if (board_x !== e.x || speed !== e.s || dir !== e.d || board_x > 10'd560) begin
            bad++;
            $display("FAIL wall_run[%0d]: got x=%0d s=%0d d=%0d required x=%0d s=%0d d=%0d",
                     n, board_x, speed, dir, e.x, e.s, e.d);
         end
      end
      total++;
      if (board_x !== 10'd560 || at_wall !== 1'b1) begin
         bad++;
         $display("FAIL wall_reach: got x=%0d w=%0d required x=560 w=1", board_x, at_wall);
      end
      pd = dir;
      for (int i = 0; i < 6; i++) begin
         do_tick(1'b0, 1'b1, 1'b0);
         e = sb.pop_front();
         total++;
         if (board_x !== e.x || speed !== e.s || dir !== e.d || at_wall !== e.w ||
             board_x !== 10'd560 || dir === pd ||
             !((dir === 2'd0 && speed === 4'd0) || (dir === 2'd2 && speed === 4'd1))) begin
            bad++;
            $display("FAIL wall_hold[%0d]: got x=%0d s=%0d d=%0d w=%0d required x=560 alternating, model s=%0d d=%0d",
                     i, board_x, speed, dir, at_wall, e.s, e.d);
         end
         pd = dir;
      end
   endtask

   task automatic test_reversal();
      bit kl[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1};
      bit kr[11] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
      async_reset();
      for (int i = 0; i < 11; i++) begin
         do_tick(kl[i], kr[i], 1'b0);
         e = sb.pop_front();
         total++;
         if (board_x !== e.x || speed !== e.s || dir !== e.d || at_wall !== e.w) begin
            bad++;
            $display("FAIL reversal_sb[%0d]: got x=%0d s=%0d d=%0d w=%0d required x=%0d s=%0d d=%0d w=%0d",
                     i, board_x, speed, dir, at_wall, e.x, e.s, e.d, e.w);
         end
         if (i == 7) begin
            total++;
            if (speed !== 4'd3 || dir !== 2'd2 || board_x !== 10'd294) begin
               bad++;
               $display("FAIL reversal_speed3: got x=%0d s=%0d d=%0d required x=294 s=3 d=2",
                        board_x, speed, dir);
            end
         end
`ifndef PADDLE_INERTIA_EN
         if (i == 8) begin
            total++;
            if (speed !== 4'd0 || dir !== 2'd0 || board_x !== 10'd294) begin
               bad++;
               $display("FAIL both_keys: got x=%0d s=%0d d=%0d required x=294 s=0 d=0",
                        board_x, speed, dir);
            end
         end
         if (i == 10) begin
            total++;
            if (speed !== 4'd1 || dir !== 2'd1 || board_x !== 10'd294) begin
               bad++;
               $display("FAIL reverse_lr: got x=%0d s=%0d d=%0d required x=294 s=1 d=1",
                        board_x, speed, dir);
            end
         end
`endif
      end
   endtask

   task automatic test_freeze();
      int xe;
      for (int i = 0; i < 11; i++) begin
         xe = mx - 1;
         do_tick(1'b1, 1'b0, i < 10);
         e = sb.pop_front();
         total++;
         if (board_x !== e.x || speed !== e.s || dir !== e.d || at_wall !== e.w) begin
            bad++;
            $display("FAIL freeze_sb[%0d]: got x=%0d s=%0d d=%0d w=%0d required x=%0d s=%0d d=%0d w=%0d",
                     i, board_x, speed, dir, at_wall, e.x, e.s, e.d, e.w);
         end
`ifndef PADDLE_INERTIA_EN
         if (i == 10) begin
            total++;
            if (board_x !== 10'(xe)) begin
               bad++;
               $display("FAIL unfreeze_step: got x=%0d required x=%0d", board_x, xe);
            end
         end
`endif
      end
      freeze = 1'b0;
   endtask

   task automatic test_no_tick();
      key_left = 1'b1; key_right = 1'b0; tick = 1'b0;
      for (int i = 0; i < 5; i++) begin
         push_model();
         @(posedge clk); #1;
         e = sb.pop_front();
         total++;
         if (board_x !== e.x || speed !== e.s || dir !== e.d || at_wall !== e.w) begin
            bad++;
            $display("FAIL no_tick[%0d]: got x=%0d s=%0d d=%0d w=%0d required x=%0d s=%0d d=%0d w=%0d",
                     i, board_x, speed, dir, at_wall, e.x, e.s, e.d, e.w);
         end
      end
      key_left = 1'b0;
   endtask

`ifdef PADDLE_INERTIA_EN
   task automatic test_inertia();
      int xs[3] = '{264, 263, 263};
      int ds[3] = '{3, 3, 0};
      async_reset();
      for (int i = 0; i < 11; i++) begin
         do_tick(i < 8, 1'b0, 1'b0);
         e = sb.pop_front();
         total++;
         if (board_x !== e.x || speed !== e.s || dir !== e.d || at_wall !== e.w) begin
            bad++;
            $display("FAIL inertia_sb[%0d]: got x=%0d s=%0d d=%0d required x=%0d s=%0d d=%0d",
                     i, board_x, speed, dir, e.x, e.s, e.d);
         end
         if (i >= 8) begin
            total++;
            if (board_x !== 10'(xs[i-8]) || dir !== 2'(ds[i-8])) begin
               bad++;
               $display("FAIL inertia_seq[%0d]: got x=%0d d=%0d required x=%0d d=%0d",
                        i - 8, board_x, dir, xs[i-8], ds[i-8]);
            end
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_accel();
      async_reset();
      for (int i = 0; i < 3; i++) begin
         do_tick(1'b0, 1'b1, 1'b0);
         e = sb.pop_front();
         total++;
         if (board_x !== e.x || speed !== e.s || dir !== e.d) begin
            bad++;
            $display("FAIL pre_reset_move[%0d]: got x=%0d s=%0d d=%0d required x=%0d s=%0d d=%0d",
                     i, board_x, speed, dir, e.x, e.s, e.d);
         end
      end
      async_reset();
      test_right_wall();
      test_reversal();
      test_freeze();
      test_no_tick();
`ifdef PADDLE_INERTIA_EN
      test_inertia();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
